param_counter: RTL and testbench
================================

# param_counter

Parametrised modulo up/down counter for the DE10-Lite lab designs, advanced by an internal clock-enable tick generator rather than a derived clock. It sits between the board clock/keys and display or LED logic, and is the general counter used by testbench and lab work. It supports selectable width, modulus, tick rate, synchronous load, a direction control and a terminal-count pulse.

## Interface
- WIDTH, 10: counter width in bits.
- MAX_COUNT, 2**WIDTH-1: highest count value; the count wraps at this value. Must be ≥1 and ≤2**WIDTH-1.
- CLK_DIV, 10: enabled clock cycles per count advance. Must be ≥1. The default gives 5 MHz from 50 MHz.
- MAX10_CLK1_50  input  1  system clock, 50 MHz.
- KEY  input  2  KEY[0]: reset, synchronous, active-low. KEY[1]: load, active-low, level-sensitive.
- en  input  1  count enable. When low, the divider and count hold.
- up_dn  input  1  1 = count up, 0 = count down.
- load_value  input  WIDTH  value captured on load.
- count  output  WIDTH  current count, registered.
- tick  output  1  one-cycle pulse, registered, marking each advance.
- tc  output  1  one-cycle pulse, registered, marking a wrap.

## Operation
- Priority at each rising edge of MAX10_CLK1_50:
  1. KEY[0]=0 (reset).
  2. KEY[1]=0 (load).
  3. Advance.
  4. Hold.
- Reset clears count, div_cnt, tick and tc to 0.
- Load:
  - count ← min(load_value, MAX_COUNT).
  - div_cnt ← 0; tick ← 0; tc ← 0.
  - Load works regardless of en.
  - While KEY[1] is held low, load repeats every cycle and the count never advances.
- Divider: div_cnt runs 0…CLK_DIV-1 while en=1. advance = en && (div_cnt == CLK_DIV-1). On advance, div_cnt ← 0.
- Advance, up:
  - count == MAX_COUNT → count ← 0, tc ← 1.
  - Otherwise count ← count+1.
- Advance, down:
  - count == 0 → count ← MAX_COUNT, tc ← 1.
  - Otherwise count ← count-1.
- On every advance tick ← 1. In every non-advance cycle tick ← 0 and tc ← 0.
- en=0: div_cnt and count hold, and tick and tc go to 0. Re-asserting en resumes from the held div_cnt; the divider phase is not lost.
- Changing up_dn takes effect at the next advance. No glitch and no extra step.
- Arithmetic is modulo MAX_COUNT+1. When MAX_COUNT < 2**WIDTH-1, count never exceeds MAX_COUNT.

## Timing
- Fully synchronous on MAX10_CLK1_50. No other clock and no asynchronous paths; KEY inputs are sampled directly and are synchronised upstream.
- First advance is visible in the cycle after CLK_DIV consecutive enabled cycles following reset release or load.
- count, tick and tc change at the same edge. tick and tc are high for exactly one cycle in the cycle where the new count is first visible.
- Steady-state advance period is CLK_DIV cycles. With CLK_DIV=1, count advances every enabled cycle and tick stays high.
- Reset or load in the same cycle as an advance: the advance is discarded, tick=0 and tc=0.

## Configuration
- COUNTER_UPDOWN_EN defined: up_dn is honoured as described above.
- COUNTER_UPDOWN_EN undefined:
  - up_dn is ignored and the block counts up only.
  - Down-wrap logic is not synthesised.
  - The port remains present so instantiations are unchanged.

## Structure
- Package counter_pkg holds:
  - DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
  - A function for the divider width, max(1, $clog2(CLK_DIV)).
- Sub-module tick_gen holds the CLK_DIV divider. Inputs: clock, reset, en, clear (driven by load). Output: advance strobe.
- param_counter instantiates tick_gen and holds the count, tick and tc registers.

## Test plan
All scenarios use WIDTH=4, MAX_COUNT=9, CLK_DIV=2 unless stated.
- Reset: KEY[0]=0 mid-count at count=5 → next edge count=0, tick=0, tc=0. The first tick comes 2 enabled cycles after release.
- Up wrap: en=1, up_dn=1 from 0 → count goes 1…9, then 0 with tc=1 for one cycle. tick pulses every 2 cycles.
- Down wrap (COUNTER_UPDOWN_EN defined): from 0 with up_dn=0 → first advance gives count=9, tc=1. With the macro undefined, the same stimulus gives count=1, tc=0.
- Load clamp and priority: load_value=12, KEY[1]=0 → count=9. Load asserted on an advance cycle → count=load value and tick=0. KEY[0] and KEY[1] both low → count=0.
- Enable hold: drop en after one enabled cycle for 5 cycles → count is unchanged and tick=0. After en=1 returns, the advance occurs 1 cycle later.
- CLK_DIV=1, WIDTH=10 defaults: count advances every cycle, 1023 → 0 with tc=1, and tick stays high.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for param_counter and its tick generator.
//   DIR_UP / DIR_DOWN : encodings of the up_dn input.
//   div_width()       : width of the clock-enable divider counter.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Divider counter width. Never narrower than one bit, so CLK_DIV=1
  // still gets a legal register.
  function automatic int div_width(input int clk_div);
    int w;
    w = $clog2(clk_div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : counter_pkg

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Clock-enable divider for param_counter. Counts 0..CLK_DIV-1 while en is
// high and raises advance during the last count of each period.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   en      : divider enable; when low the divider phase holds
//   clear   : synchronous restart of the divider (driven by load)
//   advance : combinational strobe, high for one enabled cycle per period
// -----------------------------------------------------------------------------
module tick_gen
  import counter_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic advance
);

  localparam int            DW       = div_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  assign advance = en && (div_cnt_q == DIV_LAST);

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear || advance) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  // NOTE: reset here is synchronous -- it is only looked at on the clock edge,
  // and registers use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule : tick_gen

// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
// Modulo-(MAX_COUNT+1) counter advanced by a clock-enable tick every CLK_DIV
// enabled cycles. Supports synchronous load with clamping, direction control
// and a terminal-count pulse.
//
// Build option: define COUNTER_UPDOWN_EN to honour up_dn. Without it the
// counter counts up only and up_dn is accepted but ignored.
//
// Ports:
//   MAX10_CLK1_50 : 50 MHz system clock
//   KEY[0]        : synchronous active-low reset
//   KEY[1]        : active-low level-sensitive load
//   en            : count enable (divider and count hold when low)
//   up_dn         : 1 = up, 0 = down
//   load_value    : value loaded (clamped to MAX_COUNT)
//   count         : registered count
//   tick          : registered one-cycle pulse on each advance
//   tc            : registered one-cycle pulse on each wrap
// -----------------------------------------------------------------------------
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int CLK_DIV   = 10
) (
  input  logic             MAX10_CLK1_50,
  input  logic [1:0]       KEY,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic clk;
  logic rst_n;
  logic load_n;
  logic advance;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q,  tick_d;
  logic             tc_q,    tc_d;

  assign clk    = MAX10_CLK1_50;
  assign rst_n  = KEY[0];
  assign load_n = KEY[1];

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clear   (!load_n),
    .advance (advance)
  );

`ifndef COUNTER_UPDOWN_EN
  // Kept only so the port list is identical in both builds.
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
`endif

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (!load_n) begin
      // Load overrides any advance in the same cycle.
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (advance) begin
      tick_d = 1'b1;
`ifdef COUNTER_UPDOWN_EN
      if (up_dn == DIR_DOWN) begin
        if (count_q == '0) begin
          count_d = MAX_C;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end else
`endif
      begin
        if (count_q == MAX_C) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// -----------------------------------------------------------------------------
// tb_param_counter
// Directed and randomised stimulus for param_counter (WIDTH=4, MAX_COUNT=9,
// CLK_DIV=2) against a cycle model whose predictions go through a scoreboard
// queue, plus directed checks of a second instance with CLK_DIV=1, WIDTH=10.
// Works with or without COUNTER_UPDOWN_EN defined.
// -----------------------------------------------------------------------------
module tb_param_counter;

  localparam int W   = 4;
  localparam int MC  = 9;
  localparam int CD  = 2;
  localparam int W2  = 10;

`ifdef COUNTER_UPDOWN_EN
  localparam bit UPDN = 1'b1;
`else
  localparam bit UPDN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic [1:0]    key;
  logic          en;
  logic          up_dn;
  logic [W-1:0]  load_value;
  logic [W-1:0]  count;
  logic          tick;
  logic          tc;

  logic [1:0]    key2;
  logic          en2;
  logic          up_dn2;
  logic [W2-1:0] load_value2;
  logic [W2-1:0] count2;
  logic          tick2;
  logic          tc2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    int count;
    bit tick;
    bit tc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_count = 0;
  int m_div   = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(W), .MAX_COUNT(MC), .CLK_DIV(CD)) dut (
    .MAX10_CLK1_50 (clk),
    .KEY           (key),
    .en            (en),
    .up_dn         (up_dn),
    .load_value    (load_value),
    .count         (count),
    .tick          (tick),
    .tc            (tc)
  );

  param_counter #(.WIDTH(W2), .CLK_DIV(1)) dut2 (
    .MAX10_CLK1_50 (clk),
    .KEY           (key2),
    .en            (en2),
    .up_dn         (up_dn2),
    .load_value    (load_value2),
    .count         (count2),
    .tick          (tick2),
    .tc            (tc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the next state from the inputs currently driven, queue the
  // prediction, clock once, then compare against what the DUT shows.
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    if (!key[0]) begin
      m_count = 0; m_div = 0; e.tick = 0; e.tc = 0;
    end else if (!key[1]) begin
      m_count = (int'(load_value) > MC) ? MC : int'(load_value);
      m_div = 0; e.tick = 0; e.tc = 0;
    end else if (en && m_div == CD - 1) begin
      m_div  = 0;
      e.tick = 1;
      if (UPDN && !up_dn) begin
        e.tc    = (m_count == 0);
        m_count = (m_count + MC) % (MC + 1);
      end else begin
        e.tc    = (m_count == MC);
        m_count = (m_count + 1) % (MC + 1);
      end
    end else begin
      if (en) m_div = m_div + 1;
      e.tick = 0; e.tc = 0;
    end
    e.count = m_count;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check({tag, ".count"}, 32'(count), 32'(got.count));
    check({tag, ".tick"},  32'(tick),  32'(got.tick));
    check({tag, ".tc"},    32'(tc),    32'(got.tc));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    key = 2'b10; en = 1'b0; up_dn = 1'b1; load_value = '0;
    key2 = 2'b10; en2 = 1'b0; up_dn2 = 1'b1; load_value2 = '0;
    @(negedge clk);

    // Reset state
    run("reset", 2);
    check("reset_count", 32'(count), 32'd0);

    // Count to 5, then reset mid-count
    key = 2'b11; en = 1'b1; up_dn = 1'b1;
    step("first");
    check("first_no_tick", 32'(tick), 32'd0);
    step("first");
    check("first_tick", 32'(tick), 32'd1);
    check("first_count", 32'(count), 32'd1);
    run("count5", 8);
    check("mid_count", 32'(count), 32'd5);
    key = 2'b10;
    step("reset_mid");
    check("reset_mid_count", 32'(count), 32'd0);

    // Up wrap from 0
    key = 2'b11;
    run("upwrap", 19);
    check("upwrap_pre", 32'(count), 32'd9);
    step("upwrap");
    check("upwrap_count", 32'(count), 32'd0);
    check("upwrap_tc", 32'(tc), 32'd1);
    step("upwrap_after");
    check("upwrap_tc_clear", 32'(tc), 32'd0);

    // Down wrap from 0
    key = 2'b10; step("rst_dn");
    key = 2'b11; up_dn = 1'b0;
    run("downwrap", 2);
    check("downwrap_count", 32'(count), UPDN ? 32'd9 : 32'd1);
    check("downwrap_tc", 32'(tc), UPDN ? 32'd1 : 32'd0);
    run("downrun", 6);

    // Load clamp, load held, load on advance, reset over load
    up_dn = 1'b1;
    key = 2'b01; load_value = 4'd12;
    step("load_clamp");
    check("load_clamp_count", 32'(count), 32'd9);
    load_value = 4'd4;
    run("load_held", 3);
    check("load_held_count", 32'(count), 32'd4);
    key = 2'b11;
    step("pre_adv");
    key = 2'b01; load_value = 4'd3;
    step("load_adv");
    check("load_adv_count", 32'(count), 32'd3);
    check("load_adv_tick", 32'(tick), 32'd0);
    key = 2'b00; load_value = 4'd5;
    step("rst_load");
    check("rst_load_count", 32'(count), 32'd0);

    // Enable hold keeps the divider phase
    key = 2'b11; en = 1'b1;
    step("en_one");
    en = 1'b0;
    run("en_hold", 5);
    check("en_hold_count", 32'(count), 32'd0);
    check("en_hold_tick", 32'(tick), 32'd0);
    en = 1'b1;
    step("en_resume");
    check("en_resume_tick", 32'(tick), 32'd1);
    check("en_resume_count", 32'(count), 32'd1);

    // Randomised mix of enable, direction and occasional load
    for (int i = 0; i < 80; i++) begin
      key        = ($urandom_range(0, 11) == 0) ? 2'b01 : 2'b11;
      en         = ($urandom_range(0, 3) != 0);
      up_dn      = 1'(($urandom_range(0, 5) != 0) ? (i / 20) % 2 == 0 : $urandom_range(0, 1));
      load_value = 4'($urandom_range(0, 15));
      step("random");
    end

    // CLK_DIV=1, WIDTH=10 instance: advance every cycle across the wrap
    key2 = 2'b01; load_value2 = 10'd1020;
    @(posedge clk); @(negedge clk);
    check("d1_load", 32'(count2), 32'd1020);
    key2 = 2'b11; en2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int e2;
      e2 = (1020 + i + 1) % 1024;
      @(posedge clk); @(negedge clk);
      check("d1_count", 32'(count2), 32'(e2));
      check("d1_tick", 32'(tick2), 32'd1);
      check("d1_tc", 32'(tc2), (e2 == 0) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_param_counter
